mc_main_control: RTL and testbench

Multi-cycle main control unit for the MIPS datapath. A Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives every datapath strobe and mux select, and produces `ALUop1`/`ALUop0` for the downstream ALU control stage. That stage combines them with `funct`/`opcode` to form the 4-bit ALU `Operation`.

---
 rtl/mc_main_control.sv | 188 ++++++++++++++++++
 tb/tb_mc_main_control.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control: Moore FSM, 2-5 cycles per instruction, no backpressure (opcode held by IR).
// Define MC_IMM_EN to compile EXEC_I/ITYPE_WB for addi/andi/ori; otherwise they decode as nops.
module mc_main_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ALUop1,
  output logic       ALUop0,
  output logic [1:0] PCSource,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_RTYPE_WB = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
`ifdef MC_IMM_EN
  localparam logic [3:0] S_EXEC_I   = 4'd10;
  localparam logic [3:0] S_ITYPE_WB = 4'd11;

  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  logic [3:0] next_state;
  logic       boot;
  logic       strobe_en;
  ctrl_t      ctrl;

  // boot holds the machine in FETCH for the first edge after reset falls,
  // so that edge begins the first real FETCH cycle with its strobes live.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      boot  <= 1'b1;
    end else begin
      boot  <= 1'b0;
      state <= boot ? S_FETCH : next_state;
    end
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH: next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC_R;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
`ifdef MC_IMM_EN
          OP_ADDI, OP_ANDI, OP_ORI: next_state = S_EXEC_I;
`endif
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWR:    next_state = S_FETCH;
      S_EXEC_R:   next_state = S_RTYPE_WB;
      S_RTYPE_WB: next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JUMP:     next_state = S_FETCH;
`ifdef MC_IMM_EN
      S_EXEC_I:   next_state = S_ITYPE_WB;
      S_ITYPE_WB: next_state = S_FETCH;
`endif
      default:    next_state = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: ctrl.alu_src_b = 2'b11;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
      end
      S_RTYPE_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = 2'b01;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
      end
`ifdef MC_IMM_EN
      // ALU control picks the real operation from opcode; op class stays 00.
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      S_ITYPE_WB: ctrl.reg_write = 1'b1;
`endif
      default: ctrl = '0;
    endcase
  end

  // Gating with the raw reset too keeps write strobes low in the very cycle reset arrives.
  assign strobe_en = !(reset || boot);

  assign PCWrite     = ctrl.pc_write      && strobe_en;
  assign PCWriteCond = ctrl.pc_write_cond && strobe_en;
  assign MemRead     = ctrl.mem_read      && strobe_en;
  assign MemWrite    = ctrl.mem_write     && strobe_en;
  assign IRWrite     = ctrl.ir_write      && strobe_en;
  assign RegWrite    = ctrl.reg_write     && strobe_en;
  assign IorD        = ctrl.iord;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUop1      = ctrl.alu_op[1];
  assign ALUop0      = ctrl.alu_op[0];
  assign PCSource    = ctrl.pc_source;

endmodule

// File: tb/tb_mc_main_control.sv
// Randomized instruction stream against a table-driven model of the control unit.
module tb_mc_main_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, ALUop1, ALUop0;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;
  int exp_seq[$];

  mc_main_control dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop1(ALUop1), .ALUop0(ALUop0),
    .PCSource(PCSource), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] observed_ctrl();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop1, ALUop0, PCSource};
  endfunction

  // Control word per state, straight from the state table; strobes are masked while reset gates them.
  function automatic logic [15:0] model_ctrl(input int s, input bit gated);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (s)
      0:  begin mr = 1; irw = 1; asb = 2'b01; pcw = 1; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    if (gated) {pcw, pcwc, mr, mw, irw, rw} = '0;
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs};
  endfunction

  // Expected state trace for one instruction, FETCH through its last state.
  task automatic fill_seq(input logic [5:0] op);
    exp_seq = {0, 1};
    case (op)
      6'b100011: exp_seq = {exp_seq, 2, 3, 4};
      6'b101011: exp_seq = {exp_seq, 2, 5};
      6'b000000: exp_seq = {exp_seq, 6, 7};
      6'b000100: exp_seq = {exp_seq, 8};
      6'b000010: exp_seq = {exp_seq, 9};
`ifdef MC_IMM_EN
      6'b001000, 6'b001100, 6'b001101: exp_seq = {exp_seq, 10, 11};
`endif
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_step(input string tag, input int s, input bit gated);
    check($sformatf("%s state", tag), {12'd0, state}, s[15:0]);
    check($sformatf("%s ctrl@%0d", tag, s), observed_ctrl(), model_ctrl(s, gated));
  endtask

  // Called at a falling edge with the machine in FETCH; returns at the next FETCH.
  task automatic run_instr(input logic [5:0] op);
    fill_seq(op);
    opcode = op;
    foreach (exp_seq[i]) begin
      check_step($sformatf("op%b step%0d", op, i), exp_seq[i], 1'b0);
      @(negedge clk);
    end
  endtask

  logic [5:0] legal_ops [9] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b111111};
  logic [5:0] directed  [8] = '{6'b100011, 6'b000000, 6'b000100, 6'b000010,
                                6'b001101, 6'b111111, 6'b101011, 6'b001000};

  initial begin
    reset  = 1'b1;
    opcode = 6'b000000;
    repeat (2) @(negedge clk);
    check_step("in_reset", 0, 1'b1);

    reset = 1'b0;
    #1;
    check_step("post_release_gated", 0, 1'b1);
    @(negedge clk);
    check_step("first_fetch", 0, 1'b0);

    foreach (directed[i]) run_instr(directed[i]);

    // Abort a lw in MEMRD with an asynchronous reset.
    opcode = 6'b100011;
    check_step("lw_abort fetch", 0, 1'b0);
    @(negedge clk); check_step("lw_abort decode", 1, 1'b0);
    @(negedge clk); check_step("lw_abort memadr", 2, 1'b0);
    @(negedge clk); check_step("lw_abort memrd", 3, 1'b0);
    #2 reset = 1'b1;
    #1 check_step("async_reset", 0, 1'b1);
    @(negedge clk);
    check_step("held_reset", 0, 1'b1);
    reset = 1'b0;
    #1 check_step("release_gated", 0, 1'b0 | 1'b1);
    @(negedge clk);
    check_step("refetch", 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      else op = legal_ops[$urandom_range(0, 8)];
      run_instr(op);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
